seg7_multi_display: RTL and testbench

//  Parametrised multi-digit hex seven-segment driver, successor to the single-digit combinational decoder.

---
 rtl/seg7_multi_display.sv | 131 +++++++++++++
 tb/tb_seg7_multi_display.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_multi_display.sv
// Multi-digit hex seven-segment driver: latches a value, decodes one digit per clock.
// Ports: clock/resetn, load/value/blank_lz handshake, blink_en, ready/done status, HEX segments.
module seg7_multi_display #(
  parameter int NUM_DIGITS = 6,
  parameter int BLINK_DIV  = 25000000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic                    ready,
  output logic                    done,
  output logic [7*NUM_DIGITS-1:0] HEX
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(BLINK_DIV);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(BLINK_DIV - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                  state_q;
  logic [4*NUM_DIGITS-1:0] val_q;
  logic                    lz_q;
  logic                    lzrun_q;
  logic [IW-1:0]           idx_q;
  logic                    done_q;
  // Segment registers hold "segment lit" bits; polarity is applied at the pins.
  logic [6:0]              seg_q [NUM_DIGITS];
  logic [CW-1:0]           cnt_q;
  logic                    phase_q;

  logic [3:0]              nib;
  logic [6:0]              seg_d;

  function automatic logic [6:0] dec(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  always_comb begin
    nib = val_q[4*idx_q +: 4];
    // Digit 0 is exempt so an all-zero value still shows one "0".
    if (lz_q && lzrun_q && nib == 4'h0 && idx_q != '0)
      seg_d = 7'h00;
    else
      seg_d = dec(nib);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      val_q   <= '0;
      lz_q    <= 1'b0;
      lzrun_q <= 1'b0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++)
        seg_q[k] <= 7'h00;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (load) begin
            val_q   <= value;
            lz_q    <= blank_lz;
            idx_q   <= LAST_IDX;
            lzrun_q <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          seg_q[idx_q] <= seg_d;
          if (nib != 4'h0)
            lzrun_q <= 1'b0;
          if (idx_q == '0) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
      endcase
    end
  end

  // Blink timebase runs regardless of the scan FSM.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (cnt_q == LAST_CNT) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = done_q;

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_pin
    logic [6:0] lit;
    assign lit = (blink_en && phase_q) ? 7'h00 : seg_q[k];
    assign HEX[7*k +: 7] = (ACTIVE_LOW != 0) ? ~lit : lit;
  end

endmodule

// File: tb/tb_seg7_multi_display.sv
// Self-checking bench for seg7_multi_display (4 digits, blink divider 4, active-low).
// Directed and random loads compared against a digit-level reference model.
module tb_seg7_multi_display;

  localparam int N = 4;
  localparam logic [27:0] BLANK = 28'hFFFFFFF;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic        blank_lz = 1'b0;
  logic        blink_en = 1'b0;
  logic        ready;
  logic        done;
  logic [27:0] HEX;

  int vectors = 0;
  int fails = 0;
  int ec;
  logic [27:0] cur_hex;

  logic [6:0] lut [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg7_multi_display #(
    .NUM_DIGITS(N),
    .BLINK_DIV (4),
    .ACTIVE_LOW(1)
  ) dut (
    .clock   (clock),
    .resetn  (resetn),
    .load    (load),
    .value   (value),
    .blank_lz(blank_lz),
    .blink_en(blink_en),
    .ready   (ready),
    .done    (done),
    .HEX     (HEX)
  );

  always #5 clock = ~clock;

  always @(posedge clock or negedge resetn)
    if (!resetn) ec <= 0;
    else ec <= ec + 1;

  function automatic logic [27:0] ref_hex(input logic [15:0] v, input logic lz);
    int top = 0;
    logic [27:0] r = '0;
    for (int k = 0; k < N; k++)
      if (v[4*k +: 4] != 4'h0) top = k;
    for (int k = 0; k < N; k++)
      if (lz && k > top) r[7*k +: 7] = 7'h7F;
      else r[7*k +: 7] = lut[v[4*k +: 4]];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_scan(input logic [15:0] v, input logic lz, input bit inject);
    logic [27:0] full;
    logic [27:0] exp;
    full = ref_hex(v, lz);
    value = v;
    blank_lz = lz;
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    value = 16'($urandom);
    blank_lz = ~lz;
    chk("ready_e0", {27'd0, ready}, 28'd0);
    chk("done_e0", {27'd0, done}, 28'd0);
    chk("hold_e0", HEX, cur_hex);
    for (int j = 1; j <= N; j++) begin
      if (inject && j == 2) begin
        value = ~v;
        load = 1'b1;
      end
      @(negedge clock);
      load = 1'b0;
      exp = cur_hex;
      for (int k = N - j; k < N; k++)
        exp[7*k +: 7] = full[7*k +: 7];
      chk("scan_hex", HEX, exp);
      chk("scan_ready", {27'd0, ready}, (j == N) ? 28'd1 : 28'd0);
      chk("scan_done", {27'd0, done}, (j == N) ? 28'd1 : 28'd0);
    end
    cur_hex = full;
  endtask

  initial begin
    logic [15:0] rv;
    logic rl;
    bit found;
    cur_hex = BLANK;

    repeat (3) @(negedge clock);
    chk("rst_hex", HEX, BLANK);
    chk("rst_ready", {27'd0, ready}, 28'd1);
    chk("rst_done", {27'd0, done}, 28'd0);
    resetn = 1'b1;
    @(negedge clock);
    chk("idle_hex", HEX, BLANK);
    chk("idle_done", {27'd0, done}, 28'd0);

    do_scan(16'h12AF, 1'b0, 1'b0);
    chk("d0_F", {21'd0, HEX[6:0]}, {21'd0, 7'b0001110});
    @(negedge clock);
    chk("done_once", {27'd0, done}, 28'd0);

    do_scan(16'h0040, 1'b1, 1'b0);
    chk("lz_0040", HEX, {7'h7F, 7'h7F, 7'b0011001, 7'b1000000});
    @(negedge clock);
    do_scan(16'h0000, 1'b1, 1'b0);
    chk("lz_zero", HEX, {7'h7F, 7'h7F, 7'h7F, 7'b1000000});
    @(negedge clock);

    do_scan(16'h3C5D, 1'b0, 1'b1);
    do_scan(16'h0007, 1'b1, 1'b0);
    @(negedge clock);
    chk("b2b_done", {27'd0, done}, 28'd0);

    repeat (10) begin
      rv = 16'($urandom) >> (4 * $urandom_range(0, 4));
      rl = 1'($urandom_range(0, 1));
      do_scan(rv, rl, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clock);
        chk("rnd_done", {27'd0, done}, 28'd0);
      end
    end
    @(negedge clock);

    blink_en = 1'b1;
    repeat (12) begin
      @(negedge clock);
      chk("blink", HEX, (((ec / 4) % 2) == 1) ? BLANK : cur_hex);
    end
    found = 1'b0;
    for (int t = 0; t < 20 && !found; t++) begin
      @(negedge clock);
      if (((ec / 4) % 2) == 1 && (ec % 4) == 1) found = 1'b1;
    end
    chk("blink_phase_seen", {27'd0, found}, 28'd1);
    chk("blink_on", HEX, BLANK);
    blink_en = 1'b0;
    #1;
    chk("blink_off", HEX, cur_hex);

    @(negedge clock);
    value = 16'hBEEF;
    blank_lz = 1'b0;
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    @(negedge clock);
    @(negedge clock);
    resetn = 1'b0;
    #1;
    chk("mid_rst_hex", HEX, BLANK);
    chk("mid_rst_ready", {27'd0, ready}, 28'd1);
    chk("mid_rst_done", {27'd0, done}, 28'd0);
    @(negedge clock);
    resetn = 1'b1;
    cur_hex = BLANK;
    @(negedge clock);
    do_scan(16'h0900, 1'b1, 1'b0);
    @(negedge clock);
    chk("post_rst_done", {27'd0, done}, 28'd0);
    chk("post_rst_hex", HEX, {7'h7F, 7'b0010000, 7'b1000000, 7'b1000000});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
